// File: rtl/day11_nibble_serial_comparator.sv
// Serial WIDTH-bit magnitude comparator: one 4-bit slice walked MSB nibble first, early exit.
// Optional macro SIGNED_CMP_EN selects two's-complement comparison.

module day10_4bit_comparator (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       g,
  output logic       e,
  output logic       s
);
  assign g = (a > b);
  assign e = (a == b);
  assign s = (a < b);
endmodule

module day11_nibble_serial_comparator #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = $clog2(WIDTH / 4 + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             g,
  output logic             e,
  output logic             s,
  output logic [CW-1:0]    cmp_cycles
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IdxW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : gen_bad_width
    $error("WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {StIdle, StCompare, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     cmp_q, cmp_d;
  logic              g_q, g_d, e_q, e_d, s_q, s_d;

  logic [WIDTH-1:0]  a_sh, b_sh;
  logic [3:0]        a_nib, b_nib;
  logic              sl_g, sl_e, sl_s;

  assign a_sh = a_q >> {idx_q, 2'b00};
  assign b_sh = b_q >> {idx_q, 2'b00};

`ifdef SIGNED_CMP_EN
  // Flipping the sign bit maps two's complement onto unsigned ordering.
  logic msb_nib;
  assign msb_nib = (idx_q == IdxW'(NIBBLES - 1));
  assign a_nib   = {a_sh[3] ^ msb_nib, a_sh[2:0]};
  assign b_nib   = {b_sh[3] ^ msb_nib, b_sh[2:0]};
`else
  assign a_nib   = a_sh[3:0];
  assign b_nib   = b_sh[3:0];
`endif

  day10_4bit_comparator u_slice (
    .a (a_nib),
    .b (b_nib),
    .g (sl_g),
    .e (sl_e),
    .s (sl_s)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    g_d     = g_q;
    e_d     = e_q;
    s_d     = s_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IdxW'(NIBBLES - 1);
          count_d = '0;
          state_d = StCompare;
        end
      end
      StCompare: begin
        count_d = count_q + 1'b1;
        if (sl_g || sl_s) begin
          g_d     = sl_g;
          s_d     = sl_s;
          e_d     = 1'b0;
          cmp_d   = count_q + 1'b1;
          state_d = StDone;
        end else if (idx_q == '0) begin
          g_d     = 1'b0;
          s_d     = 1'b0;
          e_d     = sl_e;
          cmp_d   = CW'(NIBBLES);
          state_d = StDone;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      count_q <= '0;
      cmp_q   <= '0;
      g_q     <= 1'b0;
      e_q     <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      g_q     <= g_d;
      e_q     <= e_d;
      s_q     <= s_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign g          = g_q;
  assign e          = e_q;
  assign s          = s_q;
  assign cmp_cycles = cmp_q;

endmodule

// File: tb/tb_day11_nibble_serial_comparator.sv
// Randomized and directed bench for day11_nibble_serial_comparator against a numeric model.

module tb_day11_nibble_serial_comparator;

  localparam int unsigned W  = 16;
  localparam int unsigned NB = W / 4;
  localparam int unsigned CW = $clog2(W / 4 + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          g, e, s;
  logic [CW-1:0] cmp_cycles;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  day11_nibble_serial_comparator #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .g          (g),
    .e          (e),
    .s          (s),
    .cmp_cycles (cmp_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Nibbles examined = position of first differing nibble counted from the top.
  function automatic int model_cycles(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int i = NB - 1; i >= 0; i--) begin
      if (((x >> (4 * i)) & 16'hF) != ((y >> (4 * i)) & 16'hF)) return NB - i;
    end
    return NB;
  endfunction

  function automatic logic [2:0] model_ges(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SIGNED_CMP_EN
    if ($signed(x) > $signed(y)) return 3'b100;
    if ($signed(x) < $signed(y)) return 3'b001;
`else
    if (x > y) return 3'b100;
    if (x < y) return 3'b001;
`endif
    return 3'b010;
  endfunction

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input int stall);
    int         k;
    logic [2:0] ges;
    int         cyc;
    ges = model_ges(ta, tb);
    cyc = model_cycles(ta, tb);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = ta;
    b = tb;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < NB + 4) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("latency", 32'(k), 32'(cyc));
    chk("ges", 32'({g, e, s}), 32'(ges));
    chk("cmp_cycles", 32'(cmp_cycles), 32'(cyc));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk);
      #1;
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_ges", 32'({g, e, s}), 32'(ges));
      chk("stall_cycles", 32'(cmp_cycles), 32'(cyc));
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_hs_valid", 32'(out_valid), 32'd0);
    chk("post_hs_ready", 32'(in_ready), 32'd1);
    chk("post_hs_hold", 32'({g, e, s}), 32'(ges));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ges", 32'({g, e, s}), 32'd0);
    chk("rst_cycles", 32'(cmp_cycles), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    run_op(16'h1234, 16'h1234, 0);
    run_op(16'h8000, 16'h7FFF, 0);
    run_op(16'h12A4, 16'h12B4, 0);
    run_op(16'h5555, 16'h5555, 10);
    run_op(16'h0001, 16'h0000, 0);

    // Async reset between edges while a 4-nibble compare is in flight.
    @(negedge clk);
    in_valid = 1'b1;
    a = 16'h0000;
    b = 16'h0001;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ges", 32'({g, e, s}), 32'd0);
    chk("arst_cycles", 32'(cmp_cycles), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NB + 2; i++) begin
      @(posedge clk);
      #1;
      chk("arst_no_result", 32'(out_valid), 32'd0);
    end
    run_op(16'hFFFF, 16'h0FFF, 0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ W'(1 << $urandom_range(0, W - 1));
        default: ;
      endcase
      run_op(ra, rb, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
